// File: rtl/switch_fabric_core_if.sv
// switch_fabric_core_if: memory-mapped slave bus of the 4x4 packet-switch core.
//   chipselect  slave select
//   write       write strobe (qualified by chipselect)
//   read        read strobe (qualified by chipselect)
//   address     4-bit register / port select
//   writedata   ingress word or command data
//   readdata    registered read data, valid one cycle after the read strobe
// Modports: master (host side), slave (core side).
interface switch_fabric_core_if;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [3:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output chipselect, write, read, address, writedata, input readdata);
   modport slave  (input chipselect, write, read, address, writedata, output readdata);
endinterface

// File: rtl/switch_fabric_core.sv
// switch_fabric_core: 4x4 packet-switch core behind a 32-bit memory-mapped slave.
// Ingress words land in 16 virtual output queues (VOQ[i][j]); a per-output,
// packet-atomic round-robin scheduler moves them into 4 output buffers that
// the host drains through the slave port.
// Ports:
//   clk    single clock, posedge
//   reset  asynchronous, active-low
//   bus    switch_fabric_core_if.slave (chipselect/write/read/address/writedata/readdata)
// Address map: 0..3 ingress / eop status, 4..7 output data, 8..11 obuf word
//   counts, 12 cycle counter, 13 clear / overflow, 14 read enable, 15 run.
// Build option: define FABRIC_CYCLE_COUNT_EN to implement the cycle counter and
//   obuf word counts; when undefined, reads of 8..12 return 0.

// Generic 1R1W synchronous RAM; q updates only on rden, otherwise holds.
module fabric_ram #(
   parameter int AW = 6,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          rden,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] q
);
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (rden) q <= mem[raddr];
   end
endmodule

module switch_fabric_core #(
   parameter int VOQ_AW  = 6,
   parameter int OBUF_AW = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   switch_fabric_core_if.slave  bus
);
   // state    | meaning
   // SCH_IDLE | output j holds no grant and arbitrates every cycle
   // SCH_BUSY | output j owns input gnt_in_q[j] until its 0 terminator lands in obuf j
   typedef enum logic {SCH_IDLE, SCH_BUSY} sch_e;

   localparam logic [VOQ_AW:0]    VOQ_FULL  = (VOQ_AW+1)'(2**VOQ_AW);
   localparam logic [VOQ_AW:0]    VOQ_ONE   = (VOQ_AW+1)'(1);
   localparam logic [OBUF_AW+1:0] OBUF_FULL = (OBUF_AW+2)'(2**OBUF_AW);
   localparam logic [OBUF_AW:0]   OBUF_ONE  = (OBUF_AW+1)'(1);

   logic [VOQ_AW:0]  voq_wr_q [16], voq_wr_d [16], voq_rd_q [16], voq_rd_d [16];
   logic [15:0]      voq_ne, voq_we, voq_re;
   logic [31:0]      voq_q [16];
   logic [OBUF_AW:0] obuf_wr_q [4], obuf_wr_d [4], obuf_rd_q [4], obuf_rd_d [4];
   logic [3:0]       obuf_we, obuf_re;
   logic [31:0]      obuf_q [4];
   logic [3:0]       eop_q, eop_d;
   logic [1:0]       port_q [4], port_d [4];
   logic             run_q, run_d, rd_en_q, rd_en_d;
   logic [15:0]      ovf_q, ovf_d;
   sch_e             sch_q [4], sch_d [4];
   logic [1:0]       gnt_in_q [4], gnt_in_d [4], rr_q [4], rr_d [4];
   logic [3:0]       infl_q, infl_d;
   logic             rd_obuf_q, rd_obuf_d;
   logic [1:0]       rd_idx_q, rd_idx_d;
   logic [31:0]      rd_val_q, rd_val_d;
   logic [1:0]       sel_in [4], gnt_cur [4];
   logic [3:0]       sel_ok, term, issue, busy;
   logic [31:0]      head [4];
   logic             wr_stb, rd_stb;
   logic [1:0]       in_idx, tgt;
   logic [3:0]       ing_v;
`ifdef FABRIC_CYCLE_COUNT_EN
   logic [31:0]      wcnt_q [4], wcnt_d [4];
   logic [31:0]      cyc_q, cyc_d;
`endif

   assign wr_stb = bus.chipselect & bus.write;
   assign rd_stb = bus.chipselect & bus.read;
   assign bus.readdata = rd_obuf_q ? obuf_q[rd_idx_q] : rd_val_q;

   always_comb begin
      for (int v = 0; v < 16; v++) voq_ne[v] = voq_wr_q[v] != voq_rd_q[v];
   end

   // Per-output arbitration and read-issue decision.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         busy[j]   = sch_q[j] == SCH_BUSY;
         sel_ok[j] = 1'b0;
         sel_in[j] = rr_q[j];
         // Scanning downward leaves the lowest offset from rr_q as the winner.
         for (int k = 3; k >= 0; k--) begin
            if (voq_ne[{rr_q[j] + 2'(k), 2'(j)}]) begin
               sel_ok[j] = 1'b1;
               sel_in[j] = rr_q[j] + 2'(k);
            end
         end
         gnt_cur[j] = busy[j] ? gnt_in_q[j] : sel_in[j];
         head[j]    = voq_q[{gnt_in_q[j], 2'(j)}];
         term[j]    = infl_q[j] && head[j] == 32'd0;
         // No read in the cycle the terminator returns, so the next packet in the
         // same VOQ is never pulled under this grant. Room counts the in-flight word.
         issue[j]   = run_q && (busy[j] || sel_ok[j]) && voq_ne[{gnt_cur[j], 2'(j)}] && !term[j]
                      && ({1'b0, obuf_wr_q[j] - obuf_rd_q[j]} + (OBUF_AW+2)'(infl_q[j])) < OBUF_FULL;
      end
   end

   always_comb begin
      voq_wr_d  = voq_wr_q;
      voq_rd_d  = voq_rd_q;
      obuf_wr_d = obuf_wr_q;
      obuf_rd_d = obuf_rd_q;
      voq_we    = '0;
      voq_re    = '0;
      obuf_we   = '0;
      obuf_re   = '0;
      eop_d     = eop_q;
      port_d    = port_q;
      run_d     = run_q;
      rd_en_d   = rd_en_q;
      ovf_d     = ovf_q;
      sch_d     = sch_q;
      gnt_in_d  = gnt_in_q;
      rr_d      = rr_q;
      infl_d    = '0;
      rd_obuf_d = 1'b0;
      rd_idx_d  = rd_idx_q;
      rd_val_d  = '0;
      in_idx    = bus.address[1:0];
      tgt       = eop_q[in_idx] ? bus.writedata[1:0] : port_q[in_idx];
      ing_v     = {in_idx, tgt};
`ifdef FABRIC_CYCLE_COUNT_EN
      wcnt_d    = wcnt_q;
      cyc_d     = cyc_q;
`endif

      if (wr_stb && bus.address[3:2] == 2'b00 && !(eop_q[in_idx] && bus.writedata == 32'd0)) begin
         if (eop_q[in_idx]) begin
            port_d[in_idx] = bus.writedata[1:0];
            eop_d[in_idx]  = 1'b0;
         end
         if (bus.writedata == 32'd0) eop_d[in_idx] = 1'b1;
         if ((voq_wr_q[ing_v] - voq_rd_q[ing_v]) == VOQ_FULL) begin
            ovf_d[ing_v] = 1'b1;
         end else begin
            voq_we[ing_v]   = 1'b1;
            voq_wr_d[ing_v] = voq_wr_q[ing_v] + VOQ_ONE;
         end
      end
      if (wr_stb && bus.address == 4'd15) run_d = 1'b1;
      if (wr_stb && bus.address == 4'd14) rd_en_d = 1'b1;

      for (int j = 0; j < 4; j++) begin
         if (infl_q[j]) begin
            obuf_we[j]   = 1'b1;
            obuf_wr_d[j] = obuf_wr_q[j] + OBUF_ONE;
`ifdef FABRIC_CYCLE_COUNT_EN
            wcnt_d[j]    = wcnt_q[j] + 32'd1;
`endif
         end
         if (term[j]) begin
            sch_d[j] = SCH_IDLE;
            rr_d[j]  = gnt_in_q[j] + 2'd1;
         end
         if (issue[j]) begin
            voq_re[{gnt_cur[j], 2'(j)}]   = 1'b1;
            voq_rd_d[{gnt_cur[j], 2'(j)}] = voq_rd_q[{gnt_cur[j], 2'(j)}] + VOQ_ONE;
            infl_d[j]   = 1'b1;
            sch_d[j]    = SCH_BUSY;
            gnt_in_d[j] = gnt_cur[j];
         end
      end

`ifdef FABRIC_CYCLE_COUNT_EN
      if (run_q && (|voq_ne || |busy) && cyc_q != '1) cyc_d = cyc_q + 32'd1;
`endif

      if (rd_stb) begin
         case (bus.address)
            4'd0, 4'd1, 4'd2, 4'd3: rd_val_d = {31'd0, eop_q[in_idx]};
            4'd4, 4'd5, 4'd6, 4'd7: begin
               if (rd_en_q && obuf_wr_q[in_idx] != obuf_rd_q[in_idx]) begin
                  obuf_re[in_idx]   = 1'b1;
                  obuf_rd_d[in_idx] = obuf_rd_q[in_idx] + OBUF_ONE;
                  rd_obuf_d         = 1'b1;
                  rd_idx_d          = in_idx;
               end
            end
`ifdef FABRIC_CYCLE_COUNT_EN
            4'd8, 4'd9, 4'd10, 4'd11: rd_val_d = wcnt_q[in_idx];
            4'd12: rd_val_d = cyc_q;
`endif
            4'd13: rd_val_d = {16'd0, ovf_q};
            default: ;
         endcase
      end

      if (wr_stb && bus.address == 4'd13) begin
         for (int v = 0; v < 16; v++) begin
            voq_wr_d[v] = '0;
            voq_rd_d[v] = '0;
         end
         for (int j = 0; j < 4; j++) begin
            obuf_wr_d[j] = '0;
            obuf_rd_d[j] = '0;
            sch_d[j]     = SCH_IDLE;
            gnt_in_d[j]  = '0;
            rr_d[j]      = '0;
`ifdef FABRIC_CYCLE_COUNT_EN
            wcnt_d[j]    = '0;
`endif
         end
         infl_d  = '0;
         eop_d   = 4'hF;
         run_d   = 1'b0;
         rd_en_d = 1'b0;
         ovf_d   = '0;
`ifdef FABRIC_CYCLE_COUNT_EN
         cyc_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int v = 0; v < 16; v++) begin
            voq_wr_q[v] <= '0;
            voq_rd_q[v] <= '0;
         end
         for (int j = 0; j < 4; j++) begin
            obuf_wr_q[j] <= '0;
            obuf_rd_q[j] <= '0;
            port_q[j]    <= '0;
            sch_q[j]     <= SCH_IDLE;
            gnt_in_q[j]  <= '0;
            rr_q[j]      <= '0;
         end
         eop_q     <= 4'hF;
         run_q     <= 1'b0;
         rd_en_q   <= 1'b0;
         ovf_q     <= '0;
         infl_q    <= '0;
         rd_obuf_q <= 1'b0;
         rd_idx_q  <= '0;
         rd_val_q  <= '0;
      end else begin
         voq_wr_q  <= voq_wr_d;
         voq_rd_q  <= voq_rd_d;
         obuf_wr_q <= obuf_wr_d;
         obuf_rd_q <= obuf_rd_d;
         port_q    <= port_d;
         sch_q     <= sch_d;
         gnt_in_q  <= gnt_in_d;
         rr_q      <= rr_d;
         eop_q     <= eop_d;
         run_q     <= run_d;
         rd_en_q   <= rd_en_d;
         ovf_q     <= ovf_d;
         infl_q    <= infl_d;
         rd_obuf_q <= rd_obuf_d;
         rd_idx_q  <= rd_idx_d;
         rd_val_q  <= rd_val_d;
      end
   end

`ifdef FABRIC_CYCLE_COUNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < 4; j++) wcnt_q[j] <= '0;
         cyc_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
         cyc_q  <= cyc_d;
      end
   end
`endif

   for (genvar v = 0; v < 16; v++) begin : g_voq
      fabric_ram #(.AW(VOQ_AW), .DW(32)) u_ram (
         .clk   (clk),
         .we    (voq_we[v]),
         .waddr (voq_wr_q[v][VOQ_AW-1:0]),
         .wdata (bus.writedata),
         .rden  (voq_re[v]),
         .raddr (voq_rd_q[v][VOQ_AW-1:0]),
         .q     (voq_q[v])
      );
   end

   for (genvar j = 0; j < 4; j++) begin : g_obuf
      fabric_ram #(.AW(OBUF_AW), .DW(32)) u_ram (
         .clk   (clk),
         .we    (obuf_we[j]),
         .waddr (obuf_wr_q[j][OBUF_AW-1:0]),
         .wdata (head[j]),
         .rden  (obuf_re[j]),
         .raddr (obuf_rd_q[j][OBUF_AW-1:0]),
         .q     (obuf_q[j])
      );
   end
endmodule

// File: tb/tb_switch_fabric_core.sv
// tb_switch_fabric_core: directed self-checking bench for switch_fabric_core.
module tb_switch_fabric_core;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [31:0] rd;

   switch_fabric_core_if bus_if ();

   switch_fabric_core #(.VOQ_AW(6), .OBUF_AW(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_if.chipselect = 1'b1; bus_if.write = 1'b1; bus_if.address = a; bus_if.writedata = d;
      @(negedge clk);
      bus_if.chipselect = 1'b0; bus_if.write = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_if.chipselect = 1'b1; bus_if.read = 1'b1; bus_if.address = a;
      @(negedge clk);
      d = bus_if.readdata;
      bus_if.chipselect = 1'b0; bus_if.read = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      bus_if.chipselect = 1'b0; bus_if.write = 1'b0; bus_if.read = 1'b0;
      bus_if.address = '0; bus_if.writedata = '0;
      reset = 1'b0;
      idle(3);
      n_cmp++;
      if (bus_if.readdata !== 32'd0) begin
         n_err++; $display("FAIL reset_readdata got %h exp %h", bus_if.readdata, 32'd0);
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus_read(4'(i), rd);
         n_cmp++;
         if (rd !== 32'd1) begin
            n_err++; $display("FAIL reset_eop%0d got %h exp %h", i, rd, 32'd1);
         end
      end
      bus_read(4'd13, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL reset_ovf got %h exp %h", rd, 32'd0); end
      bus_read(4'd6, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL reset_out2 got %h exp %h", rd, 32'd0); end
      bus_read(4'd12, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL reset_cycles got %h exp %h", rd, 32'd0); end
   endtask

   task automatic test_basic();
      logic [31:0] exp [4];
      exp = '{32'h2, 32'hA, 32'hB, 32'h0};
      bus_write(4'd13, 0);
      for (int k = 0; k < 4; k++) bus_write(4'd0, exp[k]);
      bus_write(4'd15, 0);
      idle(10);
      bus_write(4'd14, 0);
      for (int k = 0; k < 4; k++) begin
         bus_read(4'd6, rd);
         n_cmp++;
         if (rd !== exp[k]) begin n_err++; $display("FAIL basic_word%0d got %h exp %h", k, rd, exp[k]); end
      end
      bus_read(4'd6, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL basic_empty got %h exp %h", rd, 32'd0); end
`ifdef FABRIC_CYCLE_COUNT_EN
      bus_read(4'd12, rd);
      n_cmp++;
      if (rd !== 32'd5) begin n_err++; $display("FAIL basic_cycles got %0d exp %0d", rd, 5); end
      bus_read(4'd10, rd);
      n_cmp++;
      if (rd !== 32'd4) begin n_err++; $display("FAIL basic_wcnt2 got %0d exp %0d", rd, 4); end
`else
      bus_read(4'd10, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL basic_wcnt2_off got %0d exp %0d", rd, 0); end
`endif
   endtask

   task automatic test_round_robin();
      logic [31:0] exp [6];
      exp = '{32'h3, 32'h11, 32'h0, 32'h3, 32'h22, 32'h0};
      bus_write(4'd13, 0);
      bus_write(4'd0, 32'h3); bus_write(4'd0, 32'h11); bus_write(4'd0, 32'h0);
      bus_write(4'd1, 32'h3); bus_write(4'd1, 32'h22); bus_write(4'd1, 32'h0);
      bus_write(4'd15, 0);
      idle(20);
      bus_write(4'd14, 0);
      for (int k = 0; k < 6; k++) begin
         bus_read(4'd7, rd);
         n_cmp++;
         if (rd !== exp[k]) begin n_err++; $display("FAIL rr_word%0d got %h exp %h", k, rd, exp[k]); end
      end
      bus_read(4'd7, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL rr_empty got %h exp %h", rd, 32'd0); end
   endtask

   task automatic test_parallel();
      bus_write(4'd13, 0);
      for (int i = 0; i < 4; i++) begin
         bus_write(4'(i), 32'h4 + 32'(i));
         bus_write(4'(i), 32'h100 + 32'(i));
         bus_write(4'(i), 32'h0);
      end
      bus_write(4'd15, 0);
      idle(15);
`ifdef FABRIC_CYCLE_COUNT_EN
      bus_read(4'd12, rd);
      n_cmp++;
      if (rd < 32'd3 || rd > 32'd5) begin n_err++; $display("FAIL par_cycles got %0d exp 4+/-1", rd); end
      for (int j = 0; j < 4; j++) begin
         bus_read(4'd8 + 4'(j), rd);
         n_cmp++;
         if (rd !== 32'd3) begin n_err++; $display("FAIL par_wcnt%0d got %0d exp %0d", j, rd, 3); end
      end
`endif
      bus_write(4'd14, 0);
      for (int j = 0; j < 4; j++) begin
         bus_read(4'd4 + 4'(j), rd);
         n_cmp++;
         if (rd !== 32'h4 + 32'(j)) begin n_err++; $display("FAIL par_hdr%0d got %h exp %h", j, rd, 32'h4 + 32'(j)); end
         bus_read(4'd4 + 4'(j), rd);
         n_cmp++;
         if (rd !== 32'h100 + 32'(j)) begin n_err++; $display("FAIL par_data%0d got %h exp %h", j, rd, 32'h100 + 32'(j)); end
         bus_read(4'd4 + 4'(j), rd);
         n_cmp++;
         if (rd !== 32'h0) begin n_err++; $display("FAIL par_term%0d got %h exp %h", j, rd, 32'h0); end
      end
   endtask

   task automatic test_header();
      logic [31:0] exp [4];
      exp = '{32'h1, 32'hAA, 32'h0, 32'h0};
      bus_write(4'd13, 0);
      bus_write(4'd1, 32'h0);
      bus_read(4'd1, rd);
      n_cmp++;
      if (rd !== 32'd1) begin n_err++; $display("FAIL hdr_zero_eop got %h exp %h", rd, 32'd1); end
      bus_write(4'd1, 32'h1);
      bus_read(4'd1, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL hdr_open_eop got %h exp %h", rd, 32'd0); end
      bus_write(4'd1, 32'hAA);
      bus_write(4'd1, 32'h0);
      bus_read(4'd1, rd);
      n_cmp++;
      if (rd !== 32'd1) begin n_err++; $display("FAIL hdr_close_eop got %h exp %h", rd, 32'd1); end
      bus_write(4'd15, 0);
      idle(10);
      bus_write(4'd14, 0);
      for (int k = 0; k < 4; k++) begin
         bus_read(4'd5, rd);
         n_cmp++;
         if (rd !== exp[k]) begin n_err++; $display("FAIL hdr_word%0d got %h exp %h", k, rd, exp[k]); end
      end
   endtask

   task automatic test_overflow();
      bus_write(4'd13, 0);
      bus_write(4'd2, 32'h1);
      for (int k = 1; k < 64; k++) bus_write(4'd2, 32'h200 + 32'(k));
      bus_read(4'd13, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL ovf_at_full got %h exp %h", rd, 32'd0); end
      bus_write(4'd2, 32'h300);
      bus_read(4'd13, rd);
      n_cmp++;
      if (rd !== 32'h200) begin n_err++; $display("FAIL ovf_set got %h exp %h", rd, 32'h200); end
      bus_write(4'd13, 0);
      bus_read(4'd13, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL ovf_clear got %h exp %h", rd, 32'd0); end
      bus_read(4'd2, rd);
      n_cmp++;
      if (rd !== 32'd1) begin n_err++; $display("FAIL ovf_clear_eop got %h exp %h", rd, 32'd1); end
   endtask

   task automatic test_reset_mid();
      bus_write(4'd13, 0);
      bus_write(4'd0, 32'h2); bus_write(4'd0, 32'h55); bus_write(4'd0, 32'h66); bus_write(4'd0, 32'h0);
      bus_write(4'd15, 0);
      idle(10);
      bus_write(4'd14, 0);
      @(negedge clk);
      bus_if.chipselect = 1'b1; bus_if.read = 1'b1; bus_if.address = 4'd6;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus_if.readdata !== 32'h2) begin n_err++; $display("FAIL mid_pre got %h exp %h", bus_if.readdata, 32'h2); end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (bus_if.readdata !== 32'd0) begin n_err++; $display("FAIL mid_abort got %h exp %h", bus_if.readdata, 32'd0); end
      bus_if.chipselect = 1'b0; bus_if.read = 1'b0;
      idle(2);
      reset = 1'b1;
      bus_read(4'd10, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL mid_wcnt got %h exp %h", rd, 32'd0); end
      bus_read(4'd12, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL mid_cycles got %h exp %h", rd, 32'd0); end
      bus_read(4'd6, rd);
      n_cmp++;
      if (rd !== 32'd0) begin n_err++; $display("FAIL mid_out2 got %h exp %h", rd, 32'd0); end
      bus_read(4'd0, rd);
      n_cmp++;
      if (rd !== 32'd1) begin n_err++; $display("FAIL mid_eop got %h exp %h", rd, 32'd1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_parallel();
      test_header();
      test_overflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
